// File: rtl/dmem_responder_pkg.sv
// Shared LC-3b types for the data-memory responder: word, byte mask and FSM state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lc3b_dmem_state;

endpackage

// File: rtl/dmem_responder_array.sv
// Behavioural word array with a synchronous byte-masked write port and a
// combinational read; contents survive reset.
module dmem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-2:0] index,
  input  logic [15:0]          wdata,
  input  logic [1:0]           wmask,
  output logic [15:0]          rdata
);

  lc3b_word mem [2**(ADDR_BITS-1)];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[index][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[index][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// LC-3b data-memory responder: latches a request, waits LATENCY cycles, then
// pulses mem_resp. Define DMEM_STATS_EN to add read_count/write_count outputs.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_wmask,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        protocol_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  lc3b_dmem_state        state, next_state;
  logic [3:0]            count;
  logic [ADDR_BITS-2:0]  req_index;
  lc3b_word              req_wdata;
  lc3b_mem_wmask         req_wmask;
  logic                  req_write;
  lc3b_word              rdata_q;
  lc3b_word              array_rdata;
  logic                  request;
  logic                  array_we;
  logic                  unused_addr;

  assign request     = mem_read | mem_write;
  assign array_we    = mem_resp & req_write;
  assign unused_addr = ^{mem_address[15:ADDR_BITS], mem_address[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (request) next_state = WAIT;
      WAIT: begin
        if (count == 4'd0)  next_state = DONE;
        else if (!request)  next_state = IDLE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read data is steered straight from the array during a read resp so that it
  // is valid in that cycle; rdata_q keeps it afterwards.
  always_comb begin
    mem_resp  = (state == WAIT) && (count == 4'd0);
    mem_rdata = (mem_resp && !req_write) ? array_rdata : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 4'd0;
      req_index    <= '0;
      req_wdata    <= 16'h0000;
      req_wmask    <= 2'b00;
      req_write    <= 1'b0;
      rdata_q      <= 16'h0000;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            req_index <= mem_address[ADDR_BITS-1:1];
            req_wdata <= mem_wdata;
            req_wmask <= mem_wmask;
            req_write <= mem_write;
            count     <= 4'(LATENCY - 1);
            if (mem_read && mem_write) protocol_err <= 1'b1;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            if (!req_write) rdata_q <= array_rdata;
          end else if (!request) begin
            protocol_err <= 1'b1;
            count        <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count  <= 16'h0000;
      write_count <= 16'h0000;
    end else if (mem_resp) begin
      if (req_write) write_count <= write_count + 16'h0001;
      else           read_count  <= read_count + 16'h0001;
    end
  end
`endif

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (array_we),
    .index (req_index),
    .wdata (req_wdata),
    .wmask (req_wmask),
    .rdata (array_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a LATENCY=3 instance for the
// main traffic and a LATENCY=1 instance for the minimum-latency case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, rd1, wr1;
  logic [15:0] addr, wdata, addr1, wdata1;
  logic [1:0]  wmask, wmask1;
  logic        resp, resp1, perr, perr1;
  logic [15:0] rdata, rdata1;
`ifdef DMEM_STATS_EN
  logic [15:0] read_count, write_count, read_count1, write_count1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(3), .ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_address(addr),
    .mem_wdata(wdata), .mem_wmask(wmask), .mem_resp(resp), .mem_rdata(rdata),
    .protocol_err(perr)
`ifdef DMEM_STATS_EN
    , .read_count(read_count), .write_count(write_count)
`endif
  );

  dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_address(addr1),
    .mem_wdata(wdata1), .mem_wmask(wmask1), .mem_resp(resp1), .mem_rdata(rdata1),
    .protocol_err(perr1)
`ifdef DMEM_STATS_EN
    , .read_count(read_count1), .write_count(write_count1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic [1:0] m);
    if (sel) begin
      rd1 = r; wr1 = w; addr1 = a; wdata1 = d; wmask1 = m;
    end else begin
      rd = r; wr = w; addr = a; wdata = d; wmask = m;
    end
  endtask

  // Starts from an IDLE cycle (just after a rising edge), holds the request until
  // resp, returns the resp cycle number and read data, and ends in the next IDLE cycle.
  task automatic runAccess(input bit sel, input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] m,
                           output int lat, output logic [15:0] rd_val);
    lat = 0;
    rd_val = 16'h0000;
    applyStimulus(sel, r, w, a, d, m);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel ? resp1 : resp) begin
        lat = c;
        rd_val = sel ? rdata1 : rdata;
        break;
      end
    end
    @(posedge clk); #1;
    applyStimulus(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(posedge clk); #1;
  endtask

  int          lat, pulses, first_c, second_c, seen;
  logic [15:0] val;

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_resp", 32'(resp), 32'h0);
    checkOutput("reset_rdata", 32'(rdata), 32'h0);
    checkOutput("reset_err", 32'(perr), 32'h0);
    @(posedge clk); #1;

    runAccess(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, val);
    checkOutput("write_beef_latency", 32'(lat), 32'd3);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, val);
    checkOutput("read_beef_latency", 32'(lat), 32'd3);
    checkOutput("read_beef_data", 32'(val), 32'hBEEF);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, lat, val);
    checkOutput("read_odd_addr", 32'(val), 32'hBEEF);

    runAccess(1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, lat, val);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, val);
    checkOutput("low_byte_write", 32'(val), 32'hBE34);
    runAccess(1'b0, 1'b0, 1'b1, 16'h0010, 16'h5600, 2'b10, lat, val);
    checkOutput("rdata_hold_on_write", 32'(val), 32'hBE34);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, val);
    checkOutput("high_byte_write", 32'(val), 32'h5634);
    runAccess(1'b0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, lat, val);
    checkOutput("mask00_latency", 32'(lat), 32'd3);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0410, 16'h0000, 2'b00, lat, val);
    checkOutput("mask00_and_alias", 32'(val), 32'h5634);

    // Holding read continuously: one pulse per access, re-accepted only from IDLE.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
    pulses = 0; first_c = 0; second_c = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) begin
        pulses++;
        if (first_c == 0) first_c = c;
        else second_c = c;
      end
    end
    checkOutput("held_pulse_count", 32'(pulses), 32'd2);
    checkOutput("held_first_resp", 32'(first_c), 32'd3);
    checkOutput("held_second_resp", 32'(second_c), 32'd8);
    checkOutput("err_still_clear", 32'(perr), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(posedge clk); #1;

    // Write dropped while waiting aborts without a response.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 16'hAAAA, 2'b11);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) seen++;
    end
    checkOutput("abort_no_resp", 32'(seen), 32'd0);
    checkOutput("abort_err", 32'(perr), 32'h1);
    @(posedge clk); #1;
    runAccess(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, val);
    checkOutput("abort_old_word", 32'(val), 32'h5634);

    runAccess(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0F0F, 2'b11, lat, val);
    checkOutput("rw_as_write_latency", 32'(lat), 32'd3);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, val);
    checkOutput("rw_as_write_data", 32'(val), 32'h0F0F);

    // Reset during a pending write.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 16'h7777, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_resp", 32'(resp), 32'h0);
    checkOutput("midreset_rdata", 32'(rdata), 32'h0);
    checkOutput("midreset_err", 32'(perr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) seen++;
    end
    checkOutput("midreset_no_resp", 32'(seen), 32'd0);
    @(posedge clk); #1;

    runAccess(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, val);
    checkOutput("reset_keeps_array", 32'(val), 32'h5634);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, val);
    runAccess(1'b0, 1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, lat, val);
    runAccess(1'b0, 1'b0, 1'b1, 16'h0030, 16'h2222, 2'b00, lat, val);
    runAccess(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, val);
    checkOutput("read_0030", 32'(val), 32'h1111);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    #1;
`ifdef DMEM_STATS_EN
    checkOutput("read_count", 32'(read_count), 32'd3);
    checkOutput("write_count", 32'(write_count), 32'd2);
`endif

    runAccess(1'b1, 1'b0, 1'b1, 16'h0002, 16'h1234, 2'b11, lat, val);
    checkOutput("lat1_write_latency", 32'(lat), 32'd1);
    runAccess(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, val);
    checkOutput("lat1_read_latency", 32'(lat), 32'd1);
    checkOutput("lat1_read_data", 32'(val), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
